digital_lock_prog: RTL

//  Parametrised successor lock FSM: N-digit code held in a runtime-programmable register.

---
 rtl/digital_lock_prog_pkg.sv | 49 ++++
 rtl/digital_lock_prog_if.sv | 38 +++
 rtl/digital_lock_prog_timer.sv | 40 ++++
 rtl/digital_lock_prog.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_lock_prog_pkg.sv
`default_nettype none
// =============================================================================
// digital_lock_prog_pkg : shared types, widths and timer helpers for the lock
// Rev 1.0
// =============================================================================
package digital_lock_prog_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;
  localparam int TIMER_W   = 32;
  localparam int LEVEL_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_UNLOCK  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4,
    ST_CONFIRM = 3'd5
  } lock_state_e;

  typedef struct packed {
    logic wrong_try;
    logic timeout;
    logic bad_key;
    logic prog_ok;
    logic prog_fail;
  } pulse_t;

  // Left shift by level, saturating at all-ones once a set bit would fall off the top.
  function automatic logic [TIMER_W-1:0] sat_shl(input logic [TIMER_W-1:0] base,
                                                 input logic [LEVEL_W-1:0] level);
    logic [TIMER_W:0] acc;
    acc = {1'b0, base};
    for (int i = 0; i < TIMER_W + 1; i++) begin
      if ((i < int'(level)) && !acc[TIMER_W]) begin
        acc = {acc[TIMER_W-1:0], 1'b0};
      end
    end
    return acc[TIMER_W] ? {TIMER_W{1'b1}} : acc[TIMER_W-1:0];
  endfunction

  // The timer reports expiry while holding zero, so an N-cycle stay loads N-1.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input logic [TIMER_W-1:0] cycles);
    return (cycles == '0) ? '0 : (cycles - TIMER_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/digital_lock_prog_if.sv
`default_nettype none
// =============================================================================
// digital_lock_prog_if : keypad-side inputs and status/pulse outputs of the lock
// Rev 1.0
// =============================================================================
interface digital_lock_prog_if;
  import digital_lock_prog_pkg::*;

  logic [DIGIT_W-1:0] digit;
  logic               valid;
  logic               clear;
  logic               relock;
  logic               prog_start;

  logic               unlocked;
  logic               lockout;
  logic               prog_mode;
  logic [3:0]         digit_count;
  logic               wrong_try_pulse;
  logic               timeout_pulse;
  logic               bad_key_pulse;
  logic               prog_ok_pulse;
  logic               prog_fail_pulse;

  modport master (
    output digit, valid, clear, relock, prog_start,
    input  unlocked, lockout, prog_mode, digit_count,
    input  wrong_try_pulse, timeout_pulse, bad_key_pulse, prog_ok_pulse, prog_fail_pulse
  );

  modport slave (
    input  digit, valid, clear, relock, prog_start,
    output unlocked, lockout, prog_mode, digit_count,
    output wrong_try_pulse, timeout_pulse, bad_key_pulse, prog_ok_pulse, prog_fail_pulse
  );

endinterface
`default_nettype wire

// File: rtl/digital_lock_prog_timer.sv
`default_nettype none
// =============================================================================
// digital_lock_prog_timer : loadable down-counter shared by all lock timeouts
// Rev 1.0
// =============================================================================
module digital_lock_prog_timer
  import digital_lock_prog_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               load,
  input  wire logic [TIMER_W-1:0] value,
  input  wire logic               en,
  output      logic               expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/digital_lock_prog.sv
`default_nettype none
// =============================================================================
// digital_lock_prog : programmable N-digit code lock with timeout and backoff
// Rev 1.0
// =============================================================================
module digital_lock_prog
  import digital_lock_prog_pkg::*;
#(
  parameter int unsigned                CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned                MAX_ATTEMPTS   = 3,
  parameter int unsigned                LOCKOUT_CYCLES = 100_000,
  parameter int unsigned                MAX_BACKOFF    = 3,
  parameter int unsigned                ENTRY_TIMEOUT  = 50_000,
  parameter int unsigned                AUTO_RELOCK    = 0
)(
  input  wire logic          clk,
  input  wire logic          rst,
  digital_lock_prog_if.slave lock_if
);

  localparam int                 BUF_W       = DIGIT_W * CODE_LEN;
  localparam logic [3:0]         LAST_IDX    = 4'(CODE_LEN - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LOAD  = TIMER_W'(ENTRY_TIMEOUT);
  localparam logic [TIMER_W-1:0] RELOCK_LOAD = cycles_to_load(TIMER_W'(AUTO_RELOCK));
  localparam logic               ENTRY_TO_EN = (ENTRY_TIMEOUT != 0);
  localparam logic               RELOCK_EN   = (AUTO_RELOCK != 0);

  lock_state_e        state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [BUF_W-1:0]   entry_buf_q, entry_buf_d;
  logic [BUF_W-1:0]   prog_buf_q, prog_buf_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [31:0]        attempts_q, attempts_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  pulse_t             pulse_q, pulse_d;
  logic               unlocked_q, unlocked_d;
  logic               lockout_q, lockout_d;
  logic               prog_mode_q, prog_mode_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_en;
  logic               timer_expired;

  logic               key_legal;
  logic               key_bad;
  logic               last_digit;
  logic [BUF_W-1:0]   cand;
  logic [31:0]        attempts_inc;
  logic [TIMER_W-1:0] lockout_load;

  digital_lock_prog_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (timer_value),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign key_legal    = lock_if.valid && (lock_if.digit <= DIGIT_W'(MAX_DIGIT));
  assign key_bad      = lock_if.valid && (lock_if.digit >  DIGIT_W'(MAX_DIGIT));
  assign last_digit   = (count_q == LAST_IDX);
  // Keys shift in at the low end, so the first key typed ends up in the top nibble.
  assign cand         = {entry_buf_q[BUF_W-DIGIT_W-1:0], lock_if.digit};
  assign attempts_inc = attempts_q + 32'd1;
  assign lockout_load = cycles_to_load(sat_shl(TIMER_W'(LOCKOUT_CYCLES), level_q));
  assign timer_en     = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    entry_buf_d = entry_buf_q;
    prog_buf_d  = prog_buf_q;
    code_d      = code_q;
    attempts_d  = attempts_q;
    level_d     = level_q;
    pulse_d     = '0;
    timer_load  = 1'b0;
    timer_value = ENTRY_LOAD;

    unique case (state_q)
      ST_IDLE: begin
        if (!lock_if.relock && !lock_if.clear) begin
          if (key_legal) begin
            entry_buf_d = cand;
            count_d     = 4'd1;
            state_d     = ST_ENTRY;
            timer_load  = 1'b1;
          end else if (key_bad) begin
            pulse_d.bad_key = 1'b1;
          end
        end
      end

      ST_ENTRY: begin
        if (lock_if.relock || lock_if.clear) begin
          count_d     = '0;
          entry_buf_d = '0;
          state_d     = ST_IDLE;
        end else if (ENTRY_TO_EN && timer_expired) begin
          count_d         = '0;
          entry_buf_d     = '0;
          state_d         = ST_IDLE;
          pulse_d.timeout = 1'b1;
        end else if (key_legal) begin
          timer_load = 1'b1;
          if (last_digit) begin
            count_d     = '0;
            entry_buf_d = '0;
            if (cand == code_q) begin
              state_d     = ST_UNLOCK;
              attempts_d  = '0;
              level_d     = '0;
              timer_value = RELOCK_LOAD;
            end else begin
              pulse_d.wrong_try = 1'b1;
              attempts_d        = attempts_inc;
              if (attempts_inc >= 32'(MAX_ATTEMPTS)) begin
                state_d     = ST_LOCKOUT;
                timer_value = lockout_load;
                if (level_q < LEVEL_W'(MAX_BACKOFF)) begin
                  level_d = level_q + LEVEL_W'(1);
                end
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            entry_buf_d = cand;
            count_d     = count_q + 4'd1;
          end
        end else if (key_bad) begin
          pulse_d.bad_key = 1'b1;
        end
      end

      ST_UNLOCK: begin
        if (lock_if.relock || (RELOCK_EN && timer_expired)) begin
          state_d = ST_IDLE;
        end else if (lock_if.prog_start) begin
          state_d     = ST_PROG;
          count_d     = '0;
          entry_buf_d = '0;
          timer_load  = 1'b1;
        end else if (key_bad) begin
          pulse_d.bad_key = 1'b1;
        end
      end

      // Keypad inputs and relock are deliberately ignored until the penalty runs out.
      ST_LOCKOUT: begin
        if (timer_expired) begin
          state_d    = ST_IDLE;
          attempts_d = '0;
        end
      end

      ST_PROG, ST_CONFIRM: begin
        if (lock_if.relock) begin
          count_d     = '0;
          entry_buf_d = '0;
          prog_buf_d  = '0;
          state_d     = ST_IDLE;
        end else if ((ENTRY_TO_EN && timer_expired) || lock_if.clear) begin
          count_d         = '0;
          entry_buf_d     = '0;
          prog_buf_d      = '0;
          state_d         = ST_UNLOCK;
          timer_load      = 1'b1;
          timer_value     = RELOCK_LOAD;
          pulse_d.timeout = !lock_if.clear;
        end else if (key_legal) begin
          timer_load = 1'b1;
          if (last_digit) begin
            count_d     = '0;
            entry_buf_d = '0;
            if (state_q == ST_PROG) begin
              prog_buf_d = cand;
              state_d    = ST_CONFIRM;
            end else begin
              if (cand == prog_buf_q) begin
                code_d          = cand;
                pulse_d.prog_ok = 1'b1;
              end else begin
                pulse_d.prog_fail = 1'b1;
              end
              prog_buf_d  = '0;
              state_d     = ST_UNLOCK;
              timer_value = RELOCK_LOAD;
            end
          end else begin
            entry_buf_d = cand;
            count_d     = count_q + 4'd1;
          end
        end else if (key_bad) begin
          pulse_d.bad_key = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign unlocked_d  = (state_d == ST_UNLOCK) || (state_d == ST_PROG) || (state_d == ST_CONFIRM);
  assign lockout_d   = (state_d == ST_LOCKOUT);
  assign prog_mode_d = (state_d == ST_PROG) || (state_d == ST_CONFIRM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      entry_buf_q <= '0;
      prog_buf_q  <= '0;
      code_q      <= DEFAULT_CODE;
      attempts_q  <= '0;
      level_q     <= '0;
      pulse_q     <= '0;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
      prog_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      entry_buf_q <= entry_buf_d;
      prog_buf_q  <= prog_buf_d;
      code_q      <= code_d;
      attempts_q  <= attempts_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      unlocked_q  <= unlocked_d;
      lockout_q   <= lockout_d;
      prog_mode_q <= prog_mode_d;
    end
  end

  assign lock_if.unlocked        = unlocked_q;
  assign lock_if.lockout         = lockout_q;
  assign lock_if.prog_mode       = prog_mode_q;
  assign lock_if.digit_count     = count_q;
  assign lock_if.wrong_try_pulse = pulse_q.wrong_try;
  assign lock_if.timeout_pulse   = pulse_q.timeout;
  assign lock_if.bad_key_pulse   = pulse_q.bad_key;
  assign lock_if.prog_ok_pulse   = pulse_q.prog_ok;
  assign lock_if.prog_fail_pulse = pulse_q.prog_fail;

endmodule
`default_nettype wire
